pmem_arbiter: RTL and testbench

- Two-port arbiter between the instruction cache and the data cache on one side, and the single physical-memory port on the other.
- Sits directly downstream of both caches. Each cache's pmem-side interface connects to one requester port; the arbiter owns the pmem_* signals.
- Serialises line transactions with round-robin priority. Includes a per-transaction watchdog that flags a pmem response that never arrives.

---
 rtl/lc3b_types.sv | 24 ++
 rtl/arb_watchdog.sv | 46 ++++
 rtl/pmem_arbiter.sv | 128 ++++++++++++
 tb/tb_pmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory hierarchy: pmem line/address types and
// the arbiter's state and port encodings.
package lc3b_types;

  localparam int PMEM_LINE_WIDTH = 128;
  localparam int PMEM_ADDR_WIDTH = 16;

  typedef logic [PMEM_LINE_WIDTH-1:0] lc3b_pmem_line;
  typedef logic [PMEM_ADDR_WIDTH-1:0] lc3b_pmem_addr;

  // Arbiter FSM: either quiet, or owning pmem on behalf of one cache.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Which requester completed the most recent transaction.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_port_t;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating per-transaction cycle counter with a sticky timeout flag.
// Cleared when a transaction is granted; counts every serving cycle that
// does not carry pmem_resp. Reaching TIMEOUT_CYCLES latches timeout_err.
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          err_reg;

  // Next count: clear wins, otherwise increment and saturate at COUNT_MAX.
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (count_en && (count_reg != COUNT_MAX)) begin
      count_next = count_reg + CW'(1);
    end
  end

  // Counter register and sticky flag; the flag is only cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (count_next == COUNT_MAX) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign timeout_err = err_reg;

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache pmem interfaces and
// the single physical memory port. One line transaction at a time, with a
// mandatory idle cycle between transactions and a per-transaction watchdog.
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int LINE_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic                  i_pmem_resp,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic                  d_pmem_resp,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  timeout_err
);

  arb_state_t state_reg, state_next;
  arb_port_t  last_grant_reg, last_grant_next;
  // Direction of the D transaction, captured at grant so the pmem request
  // stays asserted even if the D-cache drops its strobes before pmem_resp.
  logic       d_write_op_reg, d_write_op_next;

  logic i_req;
  logic d_req;
  logic wd_clear;
  logic wd_count_en;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // State, round-robin pointer and latched D direction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_D;
      d_write_op_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      d_write_op_reg <= d_write_op_next;
    end
  end

  // Arbitration, completion and the pmem/response output mux.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    d_write_op_next = d_write_op_reg;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    pmem_address    = '0;
    pmem_wdata      = '0;
    i_pmem_resp     = 1'b0;
    i_pmem_rdata    = '0;
    d_pmem_resp     = 1'b0;
    d_pmem_rdata    = '0;

    case (state_reg)
      IDLE: begin
        // On a tie the port that did not go last wins; a stray pmem_resp
        // here is simply not routed anywhere.
        if (i_req && (!d_req || (last_grant_reg == GRANT_D))) begin
          state_next = SERVE_I;
        end else if (d_req) begin
          state_next      = SERVE_D;
          d_write_op_next = d_pmem_write;  // write beats read when both set
        end
      end

      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
        i_pmem_rdata = pmem_rdata;
        if (pmem_resp) begin
          state_next      = IDLE;
          last_grant_next = GRANT_I;
        end
      end

      SERVE_D: begin
        pmem_read    = ~d_write_op_reg;
        pmem_write   = d_write_op_reg;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
        d_pmem_rdata = pmem_rdata;
        if (pmem_resp) begin
          state_next      = IDLE;
          last_grant_next = GRANT_D;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign wd_clear    = (state_reg == IDLE) && (state_next != IDLE);
  assign wd_count_en = (state_reg != IDLE) && !pmem_resp;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (wd_clear),
    .count_en   (wd_count_en),
    .timeout_err(timeout_err)
  );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed, table-driven bench for pmem_arbiter: a per-cycle vector table
// for arbitration/routing, plus hand sequences for reset and timeout.
module tb_pmem_arbiter;

  localparam int LW = 128;
  localparam int AW = 16;
  localparam int TO = 8;

  localparam logic [LW-1:0] LA  = 128'hDEAD0000_11112222_33334444_5555BEEF;
  localparam logic [LW-1:0] LB  = 128'hB0B0B0B0_01234567_89ABCDEF_0F0F0F0F;
  localparam logic [LW-1:0] WD  = 128'hCAFEF00D_A5A5A5A5_5A5A5A5A_12345678;
  localparam logic [LW-1:0] WD2 = 128'h0BADC0DE_FEEDFACE_77778888_9999AAAA;
  localparam logic [LW-1:0] Z   = '0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic          i_pmem_resp;
  logic [LW-1:0] i_pmem_rdata;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic          d_pmem_resp;
  logic [LW-1:0] d_pmem_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;
  logic          timeout_err;

  always #5 clk = ~clk;

  pmem_arbiter #(
    .LINE_WIDTH    (LW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_resp   (i_pmem_resp),
    .i_pmem_rdata  (i_pmem_rdata),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .d_pmem_resp   (d_pmem_resp),
    .d_pmem_rdata  (d_pmem_rdata),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic          i_rd;
    logic [AW-1:0] i_addr;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic          resp;
    logic [LW-1:0] rdata;
    logic          e_pr;
    logic          e_pw;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata;
    logic          e_iresp;
    logic          e_dresp;
    logic [LW-1:0] e_irdata;
    logic [LW-1:0] e_drdata;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int row, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic i_rd, input logic [AW-1:0] i_addr, input logic d_rd, input logic d_wr,
    input logic [AW-1:0] d_addr, input logic [LW-1:0] d_wdata, input logic resp,
    input logic [LW-1:0] rdata, input logic e_pr, input logic e_pw,
    input logic [AW-1:0] e_addr, input logic [LW-1:0] e_wdata, input logic e_iresp,
    input logic e_dresp, input logic [LW-1:0] e_irdata, input logic [LW-1:0] e_drdata);
    vec_t v;
    v.i_rd = i_rd;   v.i_addr = i_addr; v.d_rd = d_rd;       v.d_wr = d_wr;
    v.d_addr = d_addr; v.d_wdata = d_wdata; v.resp = resp;   v.rdata = rdata;
    v.e_pr = e_pr;   v.e_pw = e_pw;     v.e_addr = e_addr;   v.e_wdata = e_wdata;
    v.e_iresp = e_iresp; v.e_dresp = e_dresp; v.e_irdata = e_irdata; v.e_drdata = e_drdata;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_resp      = 1'b0;
    pmem_rdata     = '0;
  endtask

  vec_t tbl[22];

  initial begin
    // Cycle-by-cycle table; starts in IDLE right after reset (last_grant = D).
    //          i_rd i_addr    d_rd d_wr d_addr    d_wdata resp rdata | pr pw addr     wdata iresp dresp irdata drdata
    // Simultaneous I read + D write: I first, idle cycle, then D write.
    tbl[0]  = mk(1, 16'h0040, 0, 1, 16'h8000, WD,  0, Z,  0, 0, 16'h0000, Z,   0, 0, Z,  Z);
    tbl[1]  = mk(1, 16'h0040, 0, 1, 16'h8000, WD,  0, Z,  1, 0, 16'h0040, Z,   0, 0, Z,  Z);
    tbl[2]  = mk(1, 16'h0040, 0, 1, 16'h8000, WD,  1, LA, 1, 0, 16'h0040, Z,   1, 0, LA, Z);
    tbl[3]  = mk(1, 16'h0060, 0, 1, 16'h8000, WD,  0, Z,  0, 0, 16'h0000, Z,   0, 0, Z,  Z);
    tbl[4]  = mk(1, 16'h0060, 0, 1, 16'h8000, WD,  0, Z,  0, 1, 16'h8000, WD,  0, 0, Z,  Z);
    tbl[5]  = mk(1, 16'h0060, 0, 1, 16'h8000, WD,  1, LB, 0, 1, 16'h8000, WD,  0, 1, Z,  LB);
    // Both keep requesting: I then D again (alternation).
    tbl[6]  = mk(1, 16'h0060, 1, 0, 16'h9000, WD,  0, Z,  0, 0, 16'h0000, Z,   0, 0, Z,  Z);
    tbl[7]  = mk(1, 16'h0060, 1, 0, 16'h9000, WD,  0, Z,  1, 0, 16'h0060, Z,   0, 0, Z,  Z);
    tbl[8]  = mk(1, 16'h0060, 1, 0, 16'h9000, WD,  1, LA, 1, 0, 16'h0060, Z,   1, 0, LA, Z);
    tbl[9]  = mk(1, 16'h0070, 1, 0, 16'h9000, WD,  0, Z,  0, 0, 16'h0000, Z,   0, 0, Z,  Z);
    tbl[10] = mk(1, 16'h0070, 1, 0, 16'h9000, WD,  0, Z,  1, 0, 16'h9000, WD,  0, 0, Z,  Z);
    tbl[11] = mk(1, 16'h0070, 1, 0, 16'h9000, WD,  1, LB, 1, 0, 16'h9000, WD,  0, 1, Z,  LB);
    // Stray pmem_resp in IDLE is ignored.
    tbl[12] = mk(0, 16'h0000, 0, 0, 16'h0000, Z,   1, LA, 0, 0, 16'h0000, Z,   0, 0, Z,  Z);
    // Single I read at 0x1230, pmem answers on the third request cycle.
    tbl[13] = mk(1, 16'h1230, 0, 0, 16'h0000, Z,   0, Z,  0, 0, 16'h0000, Z,   0, 0, Z,  Z);
    tbl[14] = mk(1, 16'h1230, 0, 0, 16'h0000, Z,   0, Z,  1, 0, 16'h1230, Z,   0, 0, Z,  Z);
    tbl[15] = mk(1, 16'h1230, 0, 0, 16'h0000, Z,   0, Z,  1, 0, 16'h1230, Z,   0, 0, Z,  Z);
    tbl[16] = mk(1, 16'h1230, 0, 0, 16'h0000, Z,   1, LA, 1, 0, 16'h1230, Z,   1, 0, LA, Z);
    // D read+write both high: write wins; strobes dropped mid-flight, request held.
    tbl[17] = mk(0, 16'h0000, 1, 1, 16'h2000, WD2, 0, Z,  0, 0, 16'h0000, Z,   0, 0, Z,  Z);
    tbl[18] = mk(0, 16'h0000, 1, 1, 16'h2000, WD2, 0, Z,  0, 1, 16'h2000, WD2, 0, 0, Z,  Z);
    tbl[19] = mk(0, 16'h0000, 0, 0, 16'h2000, WD2, 0, Z,  0, 1, 16'h2000, WD2, 0, 0, Z,  Z);
    tbl[20] = mk(0, 16'h0000, 0, 0, 16'h2000, WD2, 1, LB, 0, 1, 16'h2000, WD2, 0, 1, Z,  LB);
    tbl[21] = mk(0, 16'h0000, 0, 0, 16'h0000, Z,   0, Z,  0, 0, 16'h0000, Z,   0, 0, Z,  Z);

    // ---- Reset: outputs quiet even with a request pending.
    idle_inputs();
    reset_n     = 1'b0;
    i_pmem_read = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pmem_read", -1, LW'(pmem_read), Z);
    chk("rst_pmem_addr", -1, LW'(pmem_address), Z);
    chk("rst_timeout",   -1, LW'(timeout_err), Z);
    step();
    reset_n = 1'b1;
    i_pmem_read = 1'b0;

    // ---- Table.
    for (int r = 0; r < 22; r++) begin
      step();
      i_pmem_read    = tbl[r].i_rd;
      i_pmem_address = tbl[r].i_addr;
      d_pmem_read    = tbl[r].d_rd;
      d_pmem_write   = tbl[r].d_wr;
      d_pmem_address = tbl[r].d_addr;
      d_pmem_wdata   = tbl[r].d_wdata;
      pmem_resp      = tbl[r].resp;
      pmem_rdata     = tbl[r].rdata;
      @(negedge clk);
      chk("pmem_read",    r, LW'(pmem_read),    LW'(tbl[r].e_pr));
      chk("pmem_write",   r, LW'(pmem_write),   LW'(tbl[r].e_pw));
      chk("pmem_address", r, LW'(pmem_address), LW'(tbl[r].e_addr));
      chk("pmem_wdata",   r, pmem_wdata,        tbl[r].e_wdata);
      chk("i_pmem_resp",  r, LW'(i_pmem_resp),  LW'(tbl[r].e_iresp));
      chk("d_pmem_resp",  r, LW'(d_pmem_resp),  LW'(tbl[r].e_dresp));
      chk("i_pmem_rdata", r, i_pmem_rdata,      tbl[r].e_irdata);
      chk("d_pmem_rdata", r, d_pmem_rdata,      tbl[r].e_drdata);
      chk("timeout_err",  r, LW'(timeout_err),  Z);
      $display("row %0d: pr=%0b pw=%0b addr=%h iresp=%0b dresp=%0b err=%0b",
               r, pmem_read, pmem_write, pmem_address, i_pmem_resp, d_pmem_resp, timeout_err);
    end

    // ---- Reset in the middle of a D write-back.
    step();
    idle_inputs();
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h3000;
    d_pmem_wdata   = WD;
    step();
    @(negedge clk);
    chk("midrst_pw_before", 100, LW'(pmem_write), LW'(1'b1));
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_pw_async",   101, LW'(pmem_write), Z);
    chk("midrst_addr_async", 101, LW'(pmem_address), Z);
    chk("midrst_wdata_async",101, pmem_wdata, Z);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("postrst_pw_idle", 102, LW'(pmem_write), Z);
    chk("postrst_timeout", 102, LW'(timeout_err), Z);
    step();
    @(negedge clk);
    chk("postrst_pw_grant", 103, LW'(pmem_write), LW'(1'b1));
    chk("postrst_addr",     103, LW'(pmem_address), LW'(16'h3000));
    pmem_resp = 1'b1;
    #1;
    chk("postrst_dresp",    103, LW'(d_pmem_resp), LW'(1'b1));
    $display("mid-transaction reset sequence done: err=%0b", timeout_err);
    step();
    idle_inputs();

    // ---- Watchdog: no pmem_resp for a long time.
    step();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h0ABC;
    @(negedge clk);
    chk("to_idle_pr", 200, LW'(pmem_read), Z);
    for (int k = 1; k <= 12; k++) begin
      step();
      @(negedge clk);
      chk("to_grant_held", 200 + k, LW'(pmem_read), LW'(1'b1));
      chk("to_err",        200 + k, LW'(timeout_err), LW'(k >= 9));
    end
    step();
    pmem_resp  = 1'b1;
    pmem_rdata = LA;
    @(negedge clk);
    chk("to_late_iresp",  213, LW'(i_pmem_resp), LW'(1'b1));
    chk("to_late_irdata", 213, i_pmem_rdata, LA);
    chk("to_err_sticky",  213, LW'(timeout_err), LW'(1'b1));
    step();
    idle_inputs();
    @(negedge clk);
    chk("to_back_idle",   214, LW'(pmem_read), Z);
    chk("to_err_in_idle", 214, LW'(timeout_err), LW'(1'b1));
    $display("timeout sequence done: err=%0b", timeout_err);

    // ---- Only reset clears the sticky flag.
    #1 reset_n = 1'b0;
    #1;
    chk("final_rst_err", 300, LW'(timeout_err), Z);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("final_rel_err", 301, LW'(timeout_err), Z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
